// File: rtl/stack_engine.sv
// Stack sequencer for the 8080 core: owns SP and turns PUSH/POP/XTHL/LDSP into
// byte-wide memory accesses, with the low byte at the lower address.
module stack_engine #(
  parameter int          READ_LAT = 2,
  parameter logic [15:0] RESET_SP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [15:0] sp,
  output logic        busy,
  output logic [15:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [7:0]  mem_wdata
);

  // state   | meaning
  // IDLE    | ready for a command
  // WR_HI   | PUSH high byte write to SP-1
  // WR_LO   | PUSH low byte write to SP-2
  // RD_LO   | read address SP
  // RD_HI   | read address SP+1
  // RD_WAIT | waiting for the high byte to return
  // SW_LO   | XTHL low byte write to SP
  // SW_HI   | XTHL high byte write to SP+1
  // DONE    | one-cycle response
  typedef enum logic [3:0] {
    IDLE, WR_HI, WR_LO, RD_LO, RD_HI, RD_WAIT, SW_LO, SW_HI, DONE
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_XTHL = 2'b10;
  localparam logic [1:0] OP_LDSP = 2'b11;

  // Loaded at accept; low byte returns at count 1, high byte at terminal count 0.
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT + 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic [15:0] data_q;
  logic [2:0]  rd_cnt;
  logic [7:0]  lo_q;
  logic [15:0] word_q;
  logic        accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == DONE);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUSH: state_nxt = WR_HI;
            OP_POP,
            OP_XTHL: state_nxt = RD_LO;
            default: state_nxt = DONE;
          endcase
        end
      end
      WR_HI:   state_nxt = WR_LO;
      WR_LO:   state_nxt = DONE;
      RD_LO:   state_nxt = RD_HI;
      RD_HI:   state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (rd_cnt == 3'd0) state_nxt = (op_q == OP_XTHL) ? SW_LO : DONE;
      end
      SW_LO:   state_nxt = SW_HI;
      SW_HI:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_PUSH;
      data_q    <= 16'h0000;
      rd_cnt    <= 3'd0;
      lo_q      <= 8'h00;
      word_q    <= 16'h0000;
      sp        <= RESET_SP;
      rsp_data  <= 16'h0000;
      mem_raddr <= 16'h0000;
      mem_wen   <= 1'b0;
      mem_waddr <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rd_cnt <= CNT_INIT;
            case (cmd_op)
              OP_PUSH: begin
                mem_wen   <= 1'b1;
                mem_waddr <= sp - 16'd1;
                mem_wdata <= cmd_data[15:8];
              end
              OP_POP,
              OP_XTHL: mem_raddr <= sp;
              default: begin
                sp       <= cmd_data;
                rsp_data <= cmd_data;
              end
            endcase
          end
        end
        WR_HI: begin
          mem_waddr <= sp - 16'd2;
          mem_wdata <= data_q[7:0];
        end
        WR_LO: begin
          mem_wen  <= 1'b0;
          sp       <= sp - 16'd2;
          rsp_data <= sp - 16'd2;
        end
        RD_LO: begin
          mem_raddr <= sp + 16'd1;
          rd_cnt    <= rd_cnt - 3'd1;
        end
        RD_HI: begin
          if (rd_cnt == 3'd1) lo_q <= mem_rdata;
          rd_cnt <= rd_cnt - 3'd1;
        end
        RD_WAIT: begin
          if (rd_cnt == 3'd1) lo_q <= mem_rdata;
          if (rd_cnt != 3'd0) begin
            rd_cnt <= rd_cnt - 3'd1;
          end else if (op_q == OP_XTHL) begin
            word_q    <= {mem_rdata, lo_q};
            mem_wen   <= 1'b1;
            mem_waddr <= sp;
            mem_wdata <= data_q[7:0];
          end else begin
            rsp_data <= {mem_rdata, lo_q};
            sp       <= sp + 16'd2;
          end
        end
        SW_LO: begin
          mem_waddr <= sp + 16'd1;
          mem_wdata <= data_q[15:8];
        end
        SW_HI: begin
          mem_wen  <= 1'b0;
          rsp_data <= word_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: three instances (READ_LAT 1, 2, 4) exercised in turn
// against a word-level stack model, with a scoreboard for writes and responses.
module tb_stack_engine;

  localparam logic [1:0]  OP_PUSH  = 2'b00;
  localparam logic [1:0]  OP_POP   = 2'b01;
  localparam logic [1:0]  OP_XTHL  = 2'b10;
  localparam logic [1:0]  OP_LDSP  = 2'b11;
  localparam logic [15:0] RESET_SP = 16'h0000;

  typedef struct {
    int          lane;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  typedef struct {
    int          lane;
    logic [15:0] data;
    logic [15:0] sp;
    int          cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  cmd_valid;
  logic [2:0]  cmd_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  busy;
  logic [2:0]  mem_wen;
  logic [1:0]  cmd_op    [3];
  logic [15:0] cmd_data  [3];
  logic [15:0] rsp_data  [3];
  logic [15:0] sp        [3];
  logic [15:0] mem_raddr [3];
  logic [15:0] mem_waddr [3];
  logic [7:0]  mem_rdata [3];
  logic [7:0]  mem_wdata [3];

  bit [7:0]  mem     [65536];
  bit [7:0]  ref_mem [65536];
  bit [15:0] rpipe   [3][4];
  logic [15:0] ref_sp [3];

  wr_t  wq[$];
  rsp_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LG = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    stack_engine #(.READ_LAT(LG)) dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_data  (cmd_data[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_data  (rsp_data[g]),
      .sp        (sp[g]),
      .busy      (busy[g]),
      .mem_raddr (mem_raddr[g]),
      .mem_rdata (mem_rdata[g]),
      .mem_wen   (mem_wen[g]),
      .mem_waddr (mem_waddr[g]),
      .mem_wdata (mem_wdata[g])
    );
    assign mem_rdata[g] = mem[rpipe[g][LG-1]];
  end

  // Byte memory with a fixed read pipeline per lane
  always @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (mem_wen[l]) mem[mem_waddr[l]] <= mem_wdata[l];
      rpipe[l][0] <= mem_raddr[l];
      for (int k = 1; k < 4; k++) rpipe[l][k] <= rpipe[l][k-1];
    end
  end

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d: got %h, expected %h (cycle %0d)", name, l, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe and response must match the head of its queue
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      wr_t  w;
      rsp_t r;
      if (mem_wen[l]) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write lane %0d: got [%h]=%h, expected no write", l, mem_waddr[l], mem_wdata[l]);
        end else begin
          w = wq.pop_front();
          check("wr_lane", l, 32'(l), 32'(w.lane));
          check("wr_addr", l, 32'(mem_waddr[l]), 32'(w.addr));
          check("wr_data", l, 32'(mem_wdata[l]), 32'(w.data));
          check("wr_cycle", l, 32'(cyc), 32'(w.cyc));
        end
      end
      if (rsp_valid[l]) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp lane %0d: got rsp_data %h, expected no response", l, rsp_data[l]);
        end else begin
          r = rq.pop_front();
          check("rsp_lane", l, 32'(l), 32'(r.lane));
          check("rsp_data", l, 32'(rsp_data[l]), 32'(r.data));
          check("rsp_sp", l, 32'(sp[l]), 32'(r.sp));
          check("rsp_cycle", l, 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
  task automatic issue(input int l, input logic [1:0] op, input logic [15:0] d, input bit hold);
    int          n;
    int          t0;
    int          lat;
    logic [15:0] s;
    logic [15:0] w;
    lat          = lat_of(l);
    cmd_valid[l] = 1'b1;
    cmd_op[l]    = op;
    cmd_data[l]  = d;
    n = 0;
    while (!cmd_ready[l] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready[l]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout lane %0d: cmd_ready got 0, expected 1", l);
      cmd_valid[l] = 1'b0;
      return;
    end
    t0 = cyc;
    s  = ref_sp[l];
    case (op)
      OP_PUSH: begin
        wq.push_back('{l, s - 16'd1, d[15:8], t0 + 1});
        wq.push_back('{l, s - 16'd2, d[7:0], t0 + 2});
        ref_mem[s - 16'd1] = d[15:8];
        ref_mem[s - 16'd2] = d[7:0];
        ref_sp[l] = s - 16'd2;
        rq.push_back('{l, s - 16'd2, s - 16'd2, t0 + 3});
      end
      OP_POP: begin
        w = {ref_mem[s + 16'd1], ref_mem[s]};
        ref_sp[l] = s + 16'd2;
        rq.push_back('{l, w, s + 16'd2, t0 + 3 + lat});
      end
      OP_XTHL: begin
        w = {ref_mem[s + 16'd1], ref_mem[s]};
        wq.push_back('{l, s, d[7:0], t0 + 3 + lat});
        wq.push_back('{l, s + 16'd1, d[15:8], t0 + 4 + lat});
        ref_mem[s]         = d[7:0];
        ref_mem[s + 16'd1] = d[15:8];
        rq.push_back('{l, w, s, t0 + 5 + lat});
      end
      default: begin
        ref_sp[l] = d;
        rq.push_back('{l, d, d, t0 + 1});
      end
    endcase
    @(negedge clk);
    if (!hold) cmd_valid[l] = 1'b0;
  endtask

  task automatic drain(input int l);
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout lane %0d: got %0d rsp / %0d writes pending, expected 0", l, rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
    @(negedge clk);
    check("idle_ready", l, 32'(cmd_ready[l]), 32'd1);
    check("idle_busy", l, 32'(busy[l]), 32'd0);
    check("idle_sp", l, 32'(sp[l]), 32'(ref_sp[l]));
  endtask

  task automatic reset_mid_push(input int l);
    bit [7:0] old_hi;
    bit [7:0] old_lo;
    issue(l, OP_LDSP, 16'h3000, 1'b0);
    drain(l);
    old_hi = ref_mem[16'h2FFF];
    old_lo = ref_mem[16'h2FFE];
    issue(l, OP_PUSH, 16'hC3A7, 1'b0);
    #2;
    check("rst_pre_wen", l, 32'(mem_wen[l]), 32'd1);
    rst_n[l] = 1'b0;
    #1;
    check("rst_wen", l, 32'(mem_wen[l]), 32'd0);
    check("rst_sp", l, 32'(sp[l]), 32'(RESET_SP));
    check("rst_rsp_valid", l, 32'(rsp_valid[l]), 32'd0);
    check("rst_waddr", l, 32'(mem_waddr[l]), 32'd0);
    // The strobe was cut before its clock edge, so neither byte reached memory.
    wq.delete();
    rq.delete();
    ref_mem[16'h2FFF] = old_hi;
    ref_mem[16'h2FFE] = old_lo;
    ref_sp[l] = RESET_SP;
    repeat (3) @(negedge clk);
    rst_n[l] = 1'b1;
    #1;
    check("rst_ready", l, 32'(cmd_ready[l]), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_sp_after", l, 32'(sp[l]), 32'(RESET_SP));
  endtask

  task automatic run_lane(input int l);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    int          r;
    @(negedge clk);
    // PUSH then POP around 0x2000
    issue(l, OP_LDSP, 16'h2000, 1'b0);
    issue(l, OP_PUSH, 16'hBEEF, 1'b0);
    drain(l);
    issue(l, OP_POP, 16'h0000, 1'b0);
    drain(l);
    // XTHL on a known top word, then read the swapped word back
    issue(l, OP_PUSH, 16'h1234, 1'b0);
    issue(l, OP_XTHL, 16'hA55A, 1'b0);
    issue(l, OP_POP, 16'h0000, 1'b0);
    drain(l);
    // Address wrap in both directions
    issue(l, OP_LDSP, 16'h0000, 1'b0);
    issue(l, OP_PUSH, 16'h1122, 1'b0);
    drain(l);
    issue(l, OP_LDSP, 16'hFFFF, 1'b0);
    issue(l, OP_POP, 16'h0000, 1'b0);
    drain(l);
    // Held cmd_valid across back-to-back commands
    for (int k = 0; k < 3; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      issue(l, OP_PUSH, a, 1'b1);
      issue(l, OP_PUSH, b, 1'b1);
      issue(l, OP_POP, 16'($urandom), 1'b1);
      issue(l, OP_POP, 16'($urandom), 1'b0);
      drain(l);
    end
    reset_mid_push(l);
    // Random mix
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: d = 16'h0000;
          1: d = 16'hFFFF;
          2: d = 16'h0001;
          default: ;
        endcase
        issue(l, OP_LDSP, d, 1'($urandom_range(0, 1)));
      end else if (r <= 4) begin
        issue(l, OP_PUSH, d, 1'($urandom_range(0, 1)));
      end else if (r <= 7) begin
        issue(l, OP_POP, d, 1'($urandom_range(0, 1)));
      end else begin
        issue(l, OP_XTHL, d, 1'($urandom_range(0, 1)));
      end
    end
    cmd_valid[l] = 1'b0;
    drain(l);
  endtask

  initial begin
    rst_n     = 3'b000;
    cmd_valid = 3'b000;
    for (int l = 0; l < 3; l++) begin
      cmd_op[l]   = OP_PUSH;
      cmd_data[l] = 16'h0000;
      ref_sp[l]   = RESET_SP;
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check("reset_sp", l, 32'(sp[l]), 32'(RESET_SP));
      check("reset_rsp_valid", l, 32'(rsp_valid[l]), 32'd0);
      check("reset_rsp_data", l, 32'(rsp_data[l]), 32'd0);
      check("reset_wen", l, 32'(mem_wen[l]), 32'd0);
      check("reset_raddr", l, 32'(mem_raddr[l]), 32'd0);
    end
    rst_n = 3'b111;
    @(negedge clk);
    for (int l = 0; l < 3; l++) check("reset_ready", l, 32'(cmd_ready[l]), 32'd1);
    for (int l = 0; l < 3; l++) run_lane(l);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got to time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
